edge_rate_meter: RTL and testbench

- Measures a slow external digital signal by counting its rising edges over a fixed gate window of safe_clk cycles.
- Typical inputs are the 1 MHz-derived divided clock looped back from the PMOD header, or ex_count_out. It is the checking end of the MMCM-generated clock path.
- Runs entirely in the safe_clk domain. Reports the edge count, a one-cycle valid strobe, and pass/fail flags against an expected window.

---
 rtl/edge_rate_meter.sv | 153 +++++++++++++++
 tb/tb_edge_rate_meter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/edge_rate_meter.sv
// edge_rate_meter: counts rising edges of an asynchronous slow signal over a
// fixed window of safe_clk cycles and reports the count with range flags.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for start or continuous
//   S_GATE   | counting synchronized rising edges for GATE_CYCLES cycles
//   S_REPORT | one-cycle result strobe; loops back to S_GATE if continuous
`timescale 1ns/1ps

module edge_rate_meter #(
    parameter int unsigned GATE_CYCLES = 1000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EXP_MIN     = 0,
    parameter int unsigned EXP_MAX     = 65535
) (
    input  logic             safe_clk,
    input  logic             safe_reset_n,
    input  logic             sig_in,
    input  logic             start,
    input  logic             continuous,
    output logic             busy,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic             overflow,
    output logic             in_range,
    output logic             no_signal
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GATE   = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    localparam logic [23:0]      GATE_LAST = 24'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t                 state;
    state_t                 next_state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;
    logic                   rise;
    logic [23:0]            gate_tmr;
    logic                   gate_done;
    logic                   gate_entry;
    logic [CNT_W-1:0]       cnt;
    logic                   sat;
    logic [CNT_W-1:0]       cnt_fin;
    logic                   sat_fin;
    logic                   lo_ok;
    logic                   hi_ok;

    // Synchronize sig_in and keep the previous synchronized value for edge detect.
    always_ff @(posedge safe_clk) begin
        if (!safe_reset_n) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise       = sync_q[SYNC_STAGES-1] & ~sync_prev;
    assign gate_done  = (state == S_GATE) && (gate_tmr == GATE_LAST);
    assign gate_entry = (next_state == S_GATE) && (state != S_GATE);

    // Count value including the current cycle's edge, so the last gate cycle counts.
    assign cnt_fin = (rise && (cnt != CNT_MAX)) ? cnt + CNT_W'(1) : cnt;
    assign sat_fin = sat | (rise && (cnt == CNT_MAX));

    // Range bounds that cover the whole counter span reduce to constant true.
    if (EXP_MIN == 0) begin : g_lo_open
        assign lo_ok = 1'b1;
    end else begin : g_lo_cmp
        assign lo_ok = (cnt_fin >= CNT_W'(EXP_MIN));
    end

    if (64'(EXP_MAX) >= ((64'(1) << CNT_W) - 64'(1))) begin : g_hi_open
        assign hi_ok = 1'b1;
    end else begin : g_hi_cmp
        assign hi_ok = (cnt_fin <= CNT_W'(EXP_MAX));
    end

    // State register.
    always_ff @(posedge safe_clk) begin
        if (!safe_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start || continuous) next_state = S_GATE;
            S_GATE:   if (gate_done) next_state = S_REPORT;
            S_REPORT: next_state = continuous ? S_GATE : S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Moore outputs decoded from state.
    always_comb begin
        busy        = 1'b0;
        count_valid = 1'b0;
        case (state)
            S_GATE:   busy = 1'b1;
            S_REPORT: begin
                busy        = 1'b1;
                count_valid = 1'b1;
            end
            default:  ;
        endcase
    end

    // Gate timer and saturating edge counter; both clear on every gate entry.
    always_ff @(posedge safe_clk) begin
        if (!safe_reset_n) begin
            gate_tmr <= '0;
            cnt      <= '0;
            sat      <= 1'b0;
        end else if (gate_entry) begin
            gate_tmr <= '0;
            cnt      <= '0;
            sat      <= 1'b0;
        end else if (state == S_GATE) begin
            gate_tmr <= gate_tmr + 24'd1;
            cnt      <= cnt_fin;
            sat      <= sat_fin;
        end
    end

    // Capture the result on the last gate cycle so it is presented in REPORT and held after.
    always_ff @(posedge safe_clk) begin
        if (!safe_reset_n) begin
            count_out <= '0;
            overflow  <= 1'b0;
            in_range  <= 1'b0;
            no_signal <= 1'b0;
        end else if (gate_done) begin
            count_out <= cnt_fin;
            overflow  <= sat_fin;
            in_range  <= ~sat_fin & lo_ok & hi_ok;
            no_signal <= (cnt_fin == '0);
        end
    end

endmodule

// File: tb/tb_edge_rate_meter.sv
// Bench for edge_rate_meter: a 16-bit instance with a narrow expected window
// and a 4-bit instance for saturation, both sharing the same stimulus.
`timescale 1ns/1ps

module tb_edge_rate_meter;

    logic        safe_clk = 1'b0;
    logic        safe_reset_n;
    logic        sig_in;
    logic        start;
    logic        continuous;

    logic        busy_a, valid_a, ovf_a, inr_a, nos_a;
    logic [15:0] cnt_a;
    logic        busy_b, valid_b, ovf_b, inr_b, nos_b;
    logic [3:0]  cnt_b;

    int n_checks = 0;
    int n_fail   = 0;
    logic sig_pat [0:399];

    always #5 safe_clk = ~safe_clk;

    edge_rate_meter #(
        .GATE_CYCLES(100), .CNT_W(16), .SYNC_STAGES(2), .EXP_MIN(9), .EXP_MAX(11)
    ) dut_a (
        .safe_clk(safe_clk), .safe_reset_n(safe_reset_n), .sig_in(sig_in),
        .start(start), .continuous(continuous), .busy(busy_a),
        .count_out(cnt_a), .count_valid(valid_a), .overflow(ovf_a),
        .in_range(inr_a), .no_signal(nos_a)
    );

    edge_rate_meter #(
        .GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2), .EXP_MIN(0), .EXP_MAX(15)
    ) dut_b (
        .safe_clk(safe_clk), .safe_reset_n(safe_reset_n), .sig_in(sig_in),
        .start(start), .continuous(continuous), .busy(busy_b),
        .count_out(cnt_b), .count_valid(valid_b), .overflow(ovf_b),
        .in_range(inr_b), .no_signal(nos_b)
    );

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge safe_clk); #1;
            sig_in = 1'b0; start = 1'b0; continuous = 1'b0; safe_reset_n = 1'b1;
        end
    endtask

    task automatic fill_periodic(input int first, input int period, input int high);
        for (int i = 0; i < 400; i++)
            sig_pat[i] = (i >= first) && (((i - first) % period) < high);
    endtask

    task automatic test_reset();
        safe_reset_n = 1'b0; start = 1'b1; continuous = 1'b1; sig_in = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge safe_clk); #1;
            @(negedge safe_clk);
            if (c >= 1) begin
                n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy c=%0d got %b exp 0", c, busy_a); end
                n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid c=%0d got %b exp 0", c, valid_a); end
                n_checks++; if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL reset_count c=%0d got %0d exp 0", c, cnt_a); end
                n_checks++; if ({ovf_a, inr_a, nos_a} !== 3'b000) begin n_fail++; $display("FAIL reset_flags c=%0d got %b exp 000", c, {ovf_a, inr_a, nos_a}); end
                n_checks++; if ({busy_b, valid_b, cnt_b, ovf_b, inr_b, nos_b} !== 9'd0) begin n_fail++; $display("FAIL reset_b c=%0d got %b exp 0", c, {busy_b, valid_b, cnt_b, ovf_b, inr_b, nos_b}); end
            end
        end
        sig_in = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge safe_clk); #1;
            safe_reset_n = 1'b1; start = 1'b0; continuous = 1'b0; sig_in = 1'b0;
            @(negedge safe_clk);
            n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy c=%0d got %b exp 0", c, busy_a); end
        end
    endtask

    task automatic test_no_signal();
        for (int c = 0; c < 106; c++) begin
            @(posedge safe_clk); #1;
            sig_in = 1'b0; start = (c == 0); continuous = 1'b0;
            @(negedge safe_clk);
            if (c == 101) begin
                n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL nosig_valid got %b exp 1", valid_a); end
                n_checks++; if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL nosig_count got %0d exp 0", cnt_a); end
                n_checks++; if ({ovf_a, inr_a, nos_a} !== 3'b001) begin n_fail++; $display("FAIL nosig_flags got %b exp 001", {ovf_a, inr_a, nos_a}); end
            end
        end
        settle(5);
    endtask

    task automatic test_single();
        fill_periodic(3, 10, 5);
        for (int c = 0; c < 111; c++) begin
            @(posedge safe_clk); #1;
            sig_in = sig_pat[c]; start = (c == 0); continuous = 1'b0;
            @(negedge safe_clk);
            n_checks++; if (valid_a !== (c == 101)) begin n_fail++; $display("FAIL single_valid c=%0d got %b exp %b", c, valid_a, (c == 101)); end
            n_checks++; if (busy_a !== (c >= 1 && c <= 101)) begin n_fail++; $display("FAIL single_busy c=%0d got %b exp %b", c, busy_a, (c >= 1 && c <= 101)); end
            if (c == 101 || c == 110) begin
                n_checks++; if (cnt_a !== 16'd10) begin n_fail++; $display("FAIL single_count c=%0d got %0d exp 10", c, cnt_a); end
                n_checks++; if ({ovf_a, inr_a, nos_a} !== 3'b010) begin n_fail++; $display("FAIL single_flags c=%0d got %b exp 010", c, {ovf_a, inr_a, nos_a}); end
            end
        end
        settle(5);
    endtask

    task automatic test_saturate();
        fill_periodic(3, 2, 1);
        for (int c = 0; c < 106; c++) begin
            @(posedge safe_clk); #1;
            sig_in = sig_pat[c]; start = (c == 0); continuous = 1'b0;
            @(negedge safe_clk);
            if (c == 101) begin
                n_checks++; if (valid_b !== 1'b1) begin n_fail++; $display("FAIL sat_valid got %b exp 1", valid_b); end
                n_checks++; if (cnt_b !== 4'd15) begin n_fail++; $display("FAIL sat_count got %0d exp 15", cnt_b); end
                n_checks++; if ({ovf_b, inr_b, nos_b} !== 3'b100) begin n_fail++; $display("FAIL sat_flags got %b exp 100", {ovf_b, inr_b, nos_b}); end
                n_checks++; if ({ovf_a, inr_a, nos_a} !== 3'b000) begin n_fail++; $display("FAIL sat_wide_flags got %b exp 000", {ovf_a, inr_a, nos_a}); end
                n_checks++; if (cnt_a <= 16'd15) begin n_fail++; $display("FAIL sat_wide_count got %0d exp above 15", cnt_a); end
            end
        end
        settle(5);
    endtask

    task automatic test_continuous();
        logic exp_v;
        fill_periodic(3, 10, 5);
        for (int c = 0; c < 321; c++) begin
            @(posedge safe_clk); #1;
            sig_in = sig_pat[c]; start = 1'b0; continuous = (c < 250);
            @(negedge safe_clk);
            exp_v = (c == 101) || (c == 202) || (c == 303);
            n_checks++; if (valid_a !== exp_v) begin n_fail++; $display("FAIL cont_valid c=%0d got %b exp %b", c, valid_a, exp_v); end
            n_checks++; if (busy_a !== (c >= 1 && c <= 303)) begin n_fail++; $display("FAIL cont_busy c=%0d got %b exp %b", c, busy_a, (c >= 1 && c <= 303)); end
            if (exp_v) begin
                n_checks++; if (cnt_a !== 16'd10) begin n_fail++; $display("FAIL cont_count c=%0d got %0d exp 10", c, cnt_a); end
                n_checks++; if (inr_a !== 1'b1) begin n_fail++; $display("FAIL cont_in_range c=%0d got %b exp 1", c, inr_a); end
            end
        end
        settle(5);
    endtask

    task automatic test_reset_mid_gate();
        fill_periodic(3, 10, 5);
        for (int c = 0; c < 71; c++) begin
            @(posedge safe_clk); #1;
            sig_in = sig_pat[c]; start = (c == 0); continuous = 1'b0;
            safe_reset_n = !(c >= 50 && c < 55);
            @(negedge safe_clk);
            if (c >= 51 && c <= 55) begin
                n_checks++; if (cnt_a !== 16'd0) begin n_fail++; $display("FAIL midrst_count c=%0d got %0d exp 0", c, cnt_a); end
                n_checks++; if ({ovf_a, inr_a, nos_a} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags c=%0d got %b exp 000", c, {ovf_a, inr_a, nos_a}); end
            end
            if (c >= 51) begin
                n_checks++; if ({busy_a, valid_a} !== 2'b00) begin n_fail++; $display("FAIL midrst_busy_valid c=%0d got %b exp 00", c, {busy_a, valid_a}); end
            end
        end
        settle(3);
        for (int c = 0; c < 106; c++) begin
            @(posedge safe_clk); #1;
            sig_in = sig_pat[c]; start = (c == 0); continuous = 1'b0;
            @(negedge safe_clk);
            n_checks++; if (valid_a !== (c == 101)) begin n_fail++; $display("FAIL midrst_rerun_valid c=%0d got %b exp %b", c, valid_a, (c == 101)); end
            if (c == 101) begin
                n_checks++; if (cnt_a !== 16'd10) begin n_fail++; $display("FAIL midrst_rerun_count got %0d exp 10", cnt_a); end
            end
        end
        settle(5);
    endtask

    task automatic test_extra_start();
        fill_periodic(3, 10, 5);
        for (int c = 0; c < 116; c++) begin
            @(posedge safe_clk); #1;
            sig_in = sig_pat[c]; start = (c == 0 || c == 20 || c == 60); continuous = 1'b0;
            @(negedge safe_clk);
            n_checks++; if (valid_a !== (c == 101)) begin n_fail++; $display("FAIL xstart_valid c=%0d got %b exp %b", c, valid_a, (c == 101)); end
            n_checks++; if (busy_a !== (c >= 1 && c <= 101)) begin n_fail++; $display("FAIL xstart_busy c=%0d got %b exp %b", c, busy_a, (c >= 1 && c <= 101)); end
            if (c == 101) begin
                n_checks++; if (cnt_a !== 16'd10) begin n_fail++; $display("FAIL xstart_count got %0d exp 10", cnt_a); end
            end
        end
        settle(5);
    endtask

    // Random pulse trains kept well inside the gate; expected results follow
    // from the number of pulses alone.
    task automatic test_random();
        int t, h, l, n, lmax, hmax;
        int exp_b;
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < 400; i++) sig_pat[i] = 1'b0;
            case (it % 3)
                0: begin hmax = 3; lmax = 3; end
                1: begin hmax = 6; lmax = 6; end
                default: begin hmax = 10; lmax = 30; end
            endcase
            n = 0;
            t = (it == 5) ? 200 : 8 + int'($urandom_range(0, 6));
            while (1) begin
                h = int'($urandom_range(2, hmax));
                l = int'($urandom_range(2, lmax));
                if (t + h > 90) break;
                for (int i = t; i < t + h; i++) sig_pat[i] = 1'b1;
                n++;
                t = t + h + l;
            end
            exp_b = (n > 15) ? 15 : n;
            for (int c = 0; c < 106; c++) begin
                @(posedge safe_clk); #1;
                sig_in = sig_pat[c]; start = (c == 0); continuous = 1'b0;
                @(negedge safe_clk);
                if (c == 101) begin
                    n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL rnd_valid it=%0d got %b exp 1", it, valid_a); end
                    n_checks++; if (cnt_a !== 16'(n)) begin n_fail++; $display("FAIL rnd_count it=%0d got %0d exp %0d", it, cnt_a, n); end
                    n_checks++; if ({ovf_a, inr_a, nos_a} !== {1'b0, (n >= 9 && n <= 11), (n == 0)}) begin n_fail++; $display("FAIL rnd_flags it=%0d got %b exp %b", it, {ovf_a, inr_a, nos_a}, {1'b0, (n >= 9 && n <= 11), (n == 0)}); end
                    n_checks++; if (cnt_b !== 4'(exp_b)) begin n_fail++; $display("FAIL rnd_count4 it=%0d got %0d exp %0d", it, cnt_b, exp_b); end
                    n_checks++; if ({ovf_b, inr_b, nos_b} !== {(n > 15), (n <= 15), (n == 0)}) begin n_fail++; $display("FAIL rnd_flags4 it=%0d got %b exp %b", it, {ovf_b, inr_b, nos_b}, {(n > 15), (n <= 15), (n == 0)}); end
                end
            end
            settle(6);
        end
    endtask

    initial begin
        safe_reset_n = 1'b0; sig_in = 1'b0; start = 1'b0; continuous = 1'b0;
        test_reset();
        test_no_signal();
        test_single();
        test_saturate();
        test_continuous();
        test_reset_mid_gate();
        test_extra_start();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
